// File: rtl/dmem_responder.sv
// Single-port 64-bit data memory responder with valid/ready request and response channels.
// Optional macro DMEM_RESPONDER_ACCESS_ERR_EN flags out-of-range accesses instead of wrapping them.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic        req_wen_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] next_cnt;
  logic          accept;
  logic [63:0]   offset;
  logic [AW-1:0] idx;
  logic          hit;
  logic          unused_bits;
  logic [63:0]   rdata;
  logic [63:0]   mem [DEPTH_WORDS];

  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = (state == RESP);
  assign resp_rdata_o = rdata;
  assign accept       = req_valid_i && req_ready_o && !rst;
  assign offset       = req_addr_i - BASE_ADDR;
  assign idx          = offset[AW+2:3];

`ifdef DMEM_RESPONDER_ACCESS_ERR_EN
  logic in_range;
  logic err;
  assign in_range    = (req_addr_i >= BASE_ADDR) && ({3'b000, offset[63:3]} < 64'(DEPTH_WORDS));
  assign hit         = in_range;
  assign resp_err_o  = err;
  assign unused_bits = ^offset[2:0];
`else
  // Without error reporting the index simply wraps, so every access hits storage.
  assign hit         = 1'b1;
  assign resp_err_o  = 1'b0;
  assign unused_bits = ^{offset[63:AW+3], offset[2:0]};
`endif

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: WAIT counts down so RESP begins LATENCY cycles after acceptance.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            next_state = WAIT;
            next_cnt   = CNT_LOAD;
          end else begin
            next_state = RESP;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        next_cnt = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Storage is never reset; byte-masked writes commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_wen_i && hit) begin
      for (int k = 0; k < 8; k++) begin
        if (req_wmask_i[k]) begin
          mem[idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response payload is captured at acceptance and held until the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 64'd0;
`ifdef DMEM_RESPONDER_ACCESS_ERR_EN
      err   <= 1'b0;
`endif
    end else if (accept) begin
      rdata <= (!req_wen_i && hit) ? mem[idx] : 64'd0;
`ifdef DMEM_RESPONDER_ACCESS_ERR_EN
      err   <= !hit;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
// Covers reset, masked writes, latency, backpressure, range handling and reset mid-transaction.
module tb_dmem_responder;

  localparam int          DEPTH = 64;
  localparam int          LAT   = 3;
  localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef DMEM_RESPONDER_ACCESS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int vectors = 0;
  int fails   = 0;
  logic [63:0] ref_mem [DEPTH];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wen_i   (req_wen),
    .req_wdata_i (req_wdata),
    .req_wmask_i (req_wmask),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_err_o  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_in_range(input logic [63:0] a);
    logic [63:0] w;
    w = (a - BASE) >> 3;
    return (a >= BASE) && (w < 64'(DEPTH));
  endfunction

  function automatic int ref_index(input logic [63:0] a);
    return int'(((a - BASE) >> 3) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
    if (r == 8) return BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
    return BASE - 64'(8 * $urandom_range(1, 4));
  endfunction

  task automatic scramble_req();
    req_addr  = {$urandom, $urandom};
    req_wen   = 1'($urandom);
    req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom);
  endtask

  // One full transaction: call and return just after a rising edge (+1) with the DUT idle.
  task automatic xact(input logic [63:0] addr, input bit wen, input logic [63:0] wdata,
                      input logic [7:0] wmask, input int hold);
    bit          ok;
    int          idx;
    logic [63:0] exp_rdata;
    logic [63:0] exp_err;
    ok        = ERR_EN ? ref_in_range(addr) : 1'b1;
    idx       = ref_index(addr);
    exp_err   = (ERR_EN && !ok) ? 64'd1 : 64'd0;
    exp_rdata = (!wen && ok) ? ref_mem[idx] : 64'd0;
    if (wen && ok) begin
      for (int k = 0; k < 8; k++) begin
        if (wmask[k]) ref_mem[idx][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    check("ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wen   = wen;
    req_wdata = wdata;
    req_wmask = wmask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_req();
    for (int c = 1; c < LAT; c++) begin
      check("valid_wait", {63'd0, resp_valid}, 64'd0);
      check("ready_wait", {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    check("valid_rise", {63'd0, resp_valid}, 64'd1);
    check("ready_resp", {63'd0, req_ready}, 64'd0);
    check("rdata", resp_rdata, exp_rdata);
    check("err", {63'd0, resp_err}, exp_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_err", {63'd0, resp_err}, exp_err);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("ready_after_hs", {63'd0, req_ready}, 64'd1);
    check("valid_after_hs", {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    scramble_req();

    // Reset values, then ready in the first cycle after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", {63'd0, resp_err}, 64'd0);
    rst = 1'b0;
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < DEPTH; i++) begin
      xact(BASE + 64'(8 * i), 1'b1, {$urandom, $urandom}, 8'hFF, 0);
    end

    // Full write then read, then masked merge of the low half.
    xact(BASE + 64'h10, 1'b1, 64'h1122334455667788, 8'hFF, 0);
    xact(BASE + 64'h10, 1'b0, 64'd0, 8'h00, 0);
    check("model_full", ref_mem[2], 64'h1122334455667788);
    xact(BASE + 64'h10, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0);
    xact(BASE + 64'h10, 1'b0, 64'd0, 8'h00, 0);

    // Five cycles of backpressure on a read.
    xact(BASE + 64'h10, 1'b0, 64'd0, 8'h00, 5);

    // Empty mask leaves the word untouched.
    xact(BASE + 64'h18, 1'b1, 64'hDEADBEEFDEADBEEF, 8'h00, 1);
    xact(BASE + 64'h18, 1'b0, 64'd0, 8'h00, 0);

    // One word past the end: error, or wrap to word 0.
    xact(BASE + 64'(8 * DEPTH), 1'b0, 64'd0, 8'h00, 0);
    xact(BASE + 64'(8 * DEPTH), 1'b1, 64'h0123456789ABCDEF, 8'hFF, 0);
    xact(BASE, 1'b0, 64'd0, 8'h00, 0);
    xact(BASE - 64'd8, 1'b0, 64'd0, 8'h00, 2);

    // Reset while waiting: response dropped, write kept.
    for (int k = 0; k < 8; k++) ref_mem[5][8*k +: 8] = 8'(8'h50 + k);
    req_valid = 1'b1;
    req_addr  = BASE + 64'd40;
    req_wen   = 1'b1;
    req_wdata = 64'h5756555453525150;
    req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_req();
    check("wait_before_rst", {63'd0, req_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    for (int c = 0; c < LAT + 1; c++) begin
      check("midrst_valid", {63'd0, resp_valid}, 64'd0);
      @(posedge clk); #1;
    end
    xact(BASE + 64'd40, 1'b0, 64'd0, 8'h00, 0);

    for (int n = 0; n < 200; n++) begin
      xact(rand_addr(), 1'($urandom), {$urandom, $urandom}, 8'($urandom),
           int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
